binary_dot_product: RTL
=======================

# binary_dot_product

Accumulates one binarised dot product (XNOR + popcount) for the convolution datapath. It sits directly downstream of the filter-window address generator: image and weight memories, indexed by that generator's horizontal/vertical addresses, deliver `lanes` bits per beat here. The block sums matching bits over the window, compares the sum against a per-neuron threshold and emits one output activation bit plus the raw count.

## Interface
- `lanes`, default 8: bits per beat (popcount width).
- `accBitWidth`, default 16: accumulator, threshold and result-count width.
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-high; returns the block to IDLE.
- `startDP` in 1: one-cycle pulse that begins a new dot product and latches `threshold`.
- `threshold` in accBitWidth: unsigned activation threshold, sampled only on `startDP`.
- `dataValid` in 1: image/weight beat present.
- `dataLast` in 1: marks the final beat of the window; qualified by `dataValid`.
- `imgBits` in lanes: binarised image bits (1 = +1, 0 = -1).
- `wgtBits` in lanes: binarised weight bits, same encoding.
- `dataReady` out 1: high while in ACCUM; a beat is accepted when `dataValid && dataReady`.
- `busy` out 1: high in ACCUM and DONE.
- `resultValid` out 1: one-cycle pulse when the result is available.
- `resultBit` out 1: 1 when final sum >= latched threshold.
- `resultCount` out accBitWidth: final (possibly saturated) popcount sum.
- `overflow` out 1: sticky; set when the accumulator saturates, cleared by `startDP`.

## Operation
- States: IDLE, ACCUM, DONE (registered, 2-bit encoding).
- IDLE: `dataValid` and `dataLast` are ignored. `startDP` clears the accumulator and `overflow`, latches `threshold`, and moves to ACCUM.
- ACCUM: on each accepted beat, acc <= sat(acc + popcount(~(imgBits ^ wgtBits))), where the per-beat increment is 0..lanes.
  - An accepted beat with `dataLast`=1 moves to DONE.
  - `dataLast` without `dataValid` has no effect.
  - Cycles without `dataValid` hold all state.
- Final-beat edge: `resultCount` <= updated sum, `resultBit` <= (updated sum >= threshold), and `resultValid` <= 1. The comparison is unsigned.
- DONE: lasts exactly one cycle, then moves to IDLE. `resultValid` is high only during this cycle.
- `resultCount` and `resultBit` hold their values until the next final-beat edge or reset.
- Saturation: if acc + increment > 2^accBitWidth-1, acc holds at 2^accBitWidth-1 and `overflow` <= 1.
- `startDP` during ACCUM: restart. The accumulator is cleared, `overflow` is cleared, `threshold` is re-latched, the state stays ACCUM, and any beat presented in the same cycle is discarded.
- `startDP` during DONE: accepted. DONE still pulses `resultValid`, and the next state is ACCUM with a cleared accumulator.
- `startDP` together with `dataValid` in IDLE: the start is taken and the beat is discarded; the first beat is accepted on the following cycle.

## Timing
- Reset values:
  - state = IDLE.
  - acc = 0, latched threshold = 0.
  - `dataReady`, `busy`, `resultValid`, `resultBit` and `overflow` = 0.
  - `resultCount` = 0.
- Reset is asynchronous. When asserted mid-operation, it aborts immediately; no `resultValid` is produced for the aborted product.
- `dataReady` goes high in the cycle after the edge that samples `startDP`.
- Latency: the final beat is accepted at edge N; `resultValid`, `resultBit` and `resultCount` are valid during cycle N..N+1 (the first cycle after edge N).
- Throughput: one beat per cycle. Back-to-back products need at least one DONE cycle between them.

## Test plan
- Basic (lanes=8), threshold=10: beats (0xFF,0xFF) then last (0x0F,0x00). Required: `resultCount`=12, `resultBit`=1, `resultValid` high for exactly one cycle, immediately after the last-beat edge.
- Threshold boundary: threshold=12 with the same beats gives `resultBit`=1. threshold=13 gives `resultBit`=0 with `resultCount`=12.
- Gapped input: the same two beats with 3 idle cycles between them. Required: identical result, and `dataReady` stays high throughout ACCUM.
- Saturation (accBitWidth=4): three beats of (0xAA,0xAA), last on the third. Required: `resultCount`=15 and `overflow`=1. The next `startDP` clears `overflow` to 0.
- Restart: `startDP`, beat (0xFF,0xFF), `startDP` together with a beat, then beat (0x01,0x00) with last. Required: `resultCount`=7, so the first beat and the beat coincident with the restart are both discarded.
- Reset mid-ACCUM: assert `reset` between beats. Required: all outputs go to 0 immediately, no `resultValid` appears, and a subsequent product computes correctly from zero.

Source files
------------

// File: rtl/binary_dot_product.sv
// binary_dot_product
//   Accumulates one binarised dot product over a filter window. Each beat
//   carries `lanes` image bits and `lanes` weight bits (1 = +1, 0 = -1).
//   Matching bits are counted (XNOR + popcount) into a saturating
//   accumulator. When the final beat arrives, the sum is compared against a
//   per-neuron threshold. The block then emits one activation bit and the
//   raw count.
//
// Ports
//   clk          single clock, rising edge
//   reset        asynchronous, active-high
//   startDP      pulse: clear the accumulator, latch threshold, enter ACCUM
//   threshold    unsigned activation threshold, sampled on startDP only
//   dataValid    beat present on imgBits/wgtBits
//   dataLast     final beat of the window (qualified by dataValid)
//   imgBits      binarised image bits
//   wgtBits      binarised weight bits
//   dataReady    high in ACCUM; a beat is taken on dataValid && dataReady
//   busy         high in ACCUM and DONE
//   resultValid  one-cycle pulse in DONE
//   resultBit    final sum >= latched threshold (held until next result)
//   resultCount  final, possibly saturated, sum (held until next result)
//   overflow     sticky saturation flag, cleared by startDP
//
// State  | meaning
// -------+------------------------------------------------------------
// IDLE   | waiting for startDP; beats are ignored
// ACCUM  | accepting beats; startDP restarts the product
// DONE   | one cycle, resultValid high; startDP here goes back to ACCUM

module binary_dot_product #(
   parameter int lanes       = 8,
   parameter int accBitWidth = 16
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   startDP,
   input  logic [accBitWidth-1:0] threshold,
   input  logic                   dataValid,
   input  logic                   dataLast,
   input  logic [lanes-1:0]       imgBits,
   input  logic [lanes-1:0]       wgtBits,
   output logic                   dataReady,
   output logic                   busy,
   output logic                   resultValid,
   output logic                   resultBit,
   output logic [accBitWidth-1:0] resultCount,
   output logic                   overflow
);

   localparam int CNT_W = $clog2(lanes + 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ACCUM = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   state_t                 state_q, state_d;
   logic [accBitWidth-1:0] acc_q;
   logic [accBitWidth-1:0] thr_q;
   logic [accBitWidth-1:0] result_count_q;
   logic                   result_bit_q;
   logic                   result_valid_q;
   logic                   overflow_q;

   logic [CNT_W-1:0]       beat_ones;
   logic [accBitWidth:0]   sum_wide;
   logic [accBitWidth-1:0] sum_sat;
   logic                   sum_ovf;
   logic                   beat_take;
   logic                   beat_final;

   // Number of lanes where image and weight agree.
   always_comb begin
      beat_ones = '0;
      for (int i = 0; i < lanes; i++) begin
         beat_ones = beat_ones + CNT_W'(~(imgBits[i] ^ wgtBits[i]));
      end
   end

   // One spare bit catches the carry out; on carry the sum clamps to all-ones.
   always_comb begin
      sum_wide = {1'b0, acc_q} + (accBitWidth + 1)'(beat_ones);
      sum_ovf  = sum_wide[accBitWidth];
      sum_sat  = sum_ovf ? '1 : sum_wide[accBitWidth-1:0];
   end

   // startDP has priority: a beat in the same cycle as a (re)start is dropped.
   assign beat_take  = (state_q == ST_ACCUM) && dataValid && !startDP;
   assign beat_final = beat_take && dataLast;

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (startDP) state_d = ST_ACCUM;
         end
         ST_ACCUM: begin
            if (beat_final) state_d = ST_DONE;
         end
         ST_DONE: begin
            state_d = startDP ? ST_ACCUM : ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q        <= ST_IDLE;
         acc_q          <= '0;
         thr_q          <= '0;
         result_count_q <= '0;
         result_bit_q   <= 1'b0;
         result_valid_q <= 1'b0;
         overflow_q     <= 1'b0;
      end else begin
         state_q        <= state_d;
         result_valid_q <= beat_final;
         if (startDP) begin
            acc_q      <= '0;
            overflow_q <= 1'b0;
            thr_q      <= threshold;
         end else if (beat_take) begin
            acc_q <= sum_sat;
            if (sum_ovf) overflow_q <= 1'b1;
            if (dataLast) begin
               result_count_q <= sum_sat;
               result_bit_q   <= (sum_sat >= thr_q);
            end
         end
      end
   end

   assign dataReady   = (state_q == ST_ACCUM);
   assign busy        = (state_q == ST_ACCUM) || (state_q == ST_DONE);
   assign resultValid = result_valid_q;
   assign resultBit   = result_bit_q;
   assign resultCount = result_count_q;
   assign overflow    = overflow_q;

endmodule
